// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the ProjectB register file, write-back mux and
//   controller. It holds the default word and address widths, the register
//   file depth, and the word/address typedefs used across the datapath.
package regfile_pkg;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 4;
   localparam int RF_DEPTH = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] rf_word_t;
   typedef logic [ADDR_W-1:0] rf_addr_t;

   // Read-during-write bypass is taken when a write to the same address
   // lands on the same edge as the read request.
   function automatic logic rfBypassHit(input logic wEn, input rf_addr_t wAddr,
                                        input rf_addr_t rAddr);
      return wEn && (wAddr == rAddr);
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port
//   One registered read port of the register file, with read-during-write
//   bypass. Instantiated once per read port by register_file.
//
//   Ports:
//     Clk, ResetN      clock and asynchronous active-low reset
//     en, addr         read request and read address
//     mem              flat view of the storage array (entry i = register i)
//     W_en, W_addr,
//     W_data           the write port, used for the bypass compare
//     r_data           registered read data (holds when no request)
//     r_valid          one-cycle pulse per accepted request
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic                          Clk,
   input  logic                          ResetN,
   input  logic                          en,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
   input  logic                          W_en,
   input  logic [ADDR_W-1:0]             W_addr,
   input  logic [DATA_W-1:0]             W_data,
   output logic [DATA_W-1:0]             r_data,
   output logic                          r_valid
);

   logic bypassHit;

   // Detect a write to the address being read on this same edge. When that
   // happens the storage flops still hold the old word, so the fresh W_data
   // must be steered straight into the read-data flop instead.
   always_comb begin
      bypassHit = W_en && (W_addr == addr);
   end

   // Read-data and valid flops. Data only updates on a request so it holds
   // its last value between reads; valid simply follows the request so it
   // is high for exactly one cycle per request, back-to-back included.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= en;
         if (en) begin
            r_data <= bypassHit ? W_data : mem[addr];
         end
      end
   end

endmodule

// File: rtl/register_file.sv
// register_file
//   16 x 16-bit register file for the ProjectB datapath. It takes write-back
//   data from the write-data select mux and feeds both ALU operands through
//   two independent registered read ports, each with read-during-write bypass.
//
//   Ports:
//     Clk, ResetN           clock and asynchronous active-low reset
//     W_en, W_addr, W_data  synchronous write port
//     RA_en, RA_addr        port A read request
//     RB_en, RB_addr        port B read request
//     Ra_data, Ra_valid     port A registered data and one-cycle valid
//     Rb_data, Rb_valid     port B registered data and one-cycle valid
module register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              Clk,
   input  logic              ResetN,
   input  logic              W_en,
   input  logic [ADDR_W-1:0] W_addr,
   input  logic [DATA_W-1:0] W_data,
   input  logic              RA_en,
   input  logic [ADDR_W-1:0] RA_addr,
   input  logic              RB_en,
   input  logic [ADDR_W-1:0] RB_addr,
   output logic [DATA_W-1:0] Ra_data,
   output logic [DATA_W-1:0] Rb_data,
   output logic              Ra_valid,
   output logic              Rb_valid
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] storage;

   // Storage array and write port. Every register is writable (no hardwired
   // zero) and reset clears the whole array so a read right after reset
   // returns zero from any address.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         storage <= '0;
      end else if (W_en) begin
         storage[W_addr] <= W_data;
      end
   end

   // Port A: feeds the first ALU operand.
   rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) portA (
      .Clk     (Clk),
      .ResetN  (ResetN),
      .en      (RA_en),
      .addr    (RA_addr),
      .mem     (storage),
      .W_en    (W_en),
      .W_addr  (W_addr),
      .W_data  (W_data),
      .r_data  (Ra_data),
      .r_valid (Ra_valid)
   );

   // Port B: feeds the second ALU operand, fully independent of port A.
   rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) portB (
      .Clk     (Clk),
      .ResetN  (ResetN),
      .en      (RB_en),
      .addr    (RB_addr),
      .mem     (storage),
      .W_en    (W_en),
      .W_addr  (W_addr),
      .W_data  (W_data),
      .r_data  (Rb_data),
      .r_valid (Rb_valid)
   );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Self-checking bench for register_file. Directed scenarios plus a random
//   run are checked against a behavioural model: an array of 16 words where
//   each cycle's write is applied first and every enabled read then returns
//   the updated array content.
module tb_register_file;
   import regfile_pkg::*;

   logic     Clk;
   logic     ResetN;
   logic     W_en;
   rf_addr_t W_addr;
   rf_word_t W_data;
   logic     RA_en;
   rf_addr_t RA_addr;
   logic     RB_en;
   rf_addr_t RB_addr;
   rf_word_t Ra_data;
   rf_word_t Rb_data;
   logic     Ra_valid;
   logic     Rb_valid;

   rf_word_t refMem [RF_DEPTH];
   rf_word_t expA;
   rf_word_t expB;
   logic     expAValid;
   logic     expBValid;

   int totalChecks = 0;
   int badChecks   = 0;

   register_file dut (
      .Clk      (Clk),
      .ResetN   (ResetN),
      .W_en     (W_en),
      .W_addr   (W_addr),
      .W_data   (W_data),
      .RA_en    (RA_en),
      .RA_addr  (RA_addr),
      .RB_en    (RB_en),
      .RB_addr  (RB_addr),
      .Ra_data  (Ra_data),
      .Rb_data  (Rb_data),
      .Ra_valid (Ra_valid),
      .Rb_valid (Rb_valid)
   );

   // 10 ns clock.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s got=0x%04h exp=0x%04h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Model reset: everything cleared.
   task automatic modelReset();
      for (int i = 0; i < RF_DEPTH; i++) refMem[i] = '0;
      expA = '0; expB = '0; expAValid = 1'b0; expBValid = 1'b0;
   endtask

   // Compare all four outputs against the model.
   task automatic checkAll(input string tag);
      checkOutput({tag, ".Ra_data"},  Ra_data,          expA);
      checkOutput({tag, ".Ra_valid"}, {15'd0, Ra_valid}, {15'd0, expAValid});
      checkOutput({tag, ".Rb_data"},  Rb_data,          expB);
      checkOutput({tag, ".Rb_valid"}, {15'd0, Rb_valid}, {15'd0, expBValid});
   endtask

   // Drive one cycle of stimulus on the falling edge, let the rising edge
   // happen, update the model, then check outputs 1 ns after the edge.
   task automatic applyStimulus(input string tag,
                                input logic we, input rf_addr_t wa, input rf_word_t wd,
                                input logic ae, input rf_addr_t aa,
                                input logic be, input rf_addr_t ba);
      @(negedge Clk);
      W_en = we; W_addr = wa; W_data = wd;
      RA_en = ae; RA_addr = aa; RB_en = be; RB_addr = ba;
      @(posedge Clk);
      if (we) refMem[wa] = wd;
      expAValid = ae;
      expBValid = be;
      if (ae) expA = refMem[aa];
      if (be) expB = refMem[ba];
      #1;
      checkAll(tag);
   endtask

   task automatic idle(input string tag);
      applyStimulus(tag, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
   endtask

   initial begin
      ResetN = 1'b0;
      W_en = 1'b0; W_addr = '0; W_data = '0;
      RA_en = 1'b0; RA_addr = '0; RB_en = 1'b0; RB_addr = '0;
      modelReset();
      #12;
      checkAll("resetState");
      @(negedge Clk);
      ResetN = 1'b1;

      // Reset: write BEEF to R3, then assert reset mid-cycle with a write
      // and reads in flight; all of it must be discarded.
      applyStimulus("wrR3", 1'b1, 4'd3, 16'hBEEF, 1'b1, 4'd3, 1'b0, 4'd0);
      @(negedge Clk);
      W_en = 1'b1; W_addr = 4'd3; W_data = 16'h5A5A;
      RA_en = 1'b1; RA_addr = 4'd3; RB_en = 1'b1; RB_addr = 4'd3;
      #2;
      ResetN = 1'b0;
      modelReset();
      #1;
      checkAll("midReset");
      @(posedge Clk);
      #1;
      checkAll("heldReset");
      @(negedge Clk);
      ResetN = 1'b1;
      W_en = 1'b0; RA_en = 1'b0; RB_en = 1'b0;
      applyStimulus("rdR3AfterReset", 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd0);
      checkOutput("rdR3AfterReset.const", Ra_data, 16'h0000);

      // Basic write then read, valid drops the cycle after.
      applyStimulus("wrR5", 1'b1, 4'd5, 16'h0007, 1'b0, 4'd0, 1'b0, 4'd0);
      applyStimulus("rdR5", 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b0, 4'd0);
      checkOutput("rdR5.const", Ra_data, 16'h0007);
      idle("rdR5.validDrop");

      // Same-cycle bypass on both ports.
      applyStimulus("wrR9", 1'b1, 4'd9, 16'h1111, 1'b0, 4'd0, 1'b0, 4'd0);
      applyStimulus("bypassR9", 1'b1, 4'd9, 16'h000F, 1'b1, 4'd9, 1'b1, 4'd9);
      checkOutput("bypassR9.constA", Ra_data, 16'h000F);
      checkOutput("bypassR9.constB", Rb_data, 16'h000F);

      // Dual independent ports with swapped addresses.
      applyStimulus("wrR1", 1'b1, 4'd1, 16'h0001, 1'b0, 4'd0, 1'b0, 4'd0);
      applyStimulus("wrR15", 1'b1, 4'd15, 16'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0);
      applyStimulus("dualA1B15", 1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 1'b1, 4'd15);
      applyStimulus("dualA15B1", 1'b0, 4'd0, 16'h0, 1'b1, 4'd15, 1'b1, 4'd1);
      applyStimulus("rdA1", 1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 1'b0, 4'd0);

      // Hold: no request while R1 is overwritten; data holds, valid low.
      applyStimulus("hold", 1'b1, 4'd1, 16'h2222, 1'b0, 4'd1, 1'b0, 4'd0);
      checkOutput("hold.const", Ra_data, 16'h0001);
      idle("hold2");
      applyStimulus("rdR1New", 1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 1'b0, 4'd0);

      // Full sweep: addr*0x1111 everywhere, then read back A up, B down.
      for (int i = 0; i < RF_DEPTH; i++)
         applyStimulus("sweepWr", 1'b1, rf_addr_t'(i), rf_word_t'(i * 16'h1111),
                       1'b0, 4'd0, 1'b0, 4'd0);
      for (int i = 0; i < RF_DEPTH; i++) begin
         applyStimulus("sweepRd", 1'b0, 4'd0, 16'h0, 1'b1, rf_addr_t'(i),
                       1'b1, rf_addr_t'(RF_DEPTH - 1 - i));
         checkOutput("sweepRd.constA", Ra_data, rf_word_t'(i * 16'h1111));
      end
      idle("sweepEnd");

      // Random traffic; addresses sometimes drawn from a narrow range so
      // same-cycle write/read collisions are frequent.
      for (int n = 0; n < 400; n++) begin
         logic     narrow;
         rf_addr_t wa, aa, ba;
         narrow = ($urandom_range(0, 1) == 1);
         wa = narrow ? rf_addr_t'($urandom_range(0, 2)) : rf_addr_t'($urandom_range(0, 15));
         aa = narrow ? rf_addr_t'($urandom_range(0, 2)) : rf_addr_t'($urandom_range(0, 15));
         ba = narrow ? rf_addr_t'($urandom_range(0, 2)) : rf_addr_t'($urandom_range(0, 15));
         applyStimulus("random", 1'($urandom_range(0, 1)), wa, rf_word_t'($urandom),
                       1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), ba);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
